// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer around an external combinational 16-bit ALU with an 8x16 register file.
// One instruction in flight: IDLE -> FETCH -> EXEC -> WB for ALU ops, IDLE -> WB for LOAD/NOP.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [2:0]  in_dst,
    input  logic [2:0]  in_srcr,
    input  logic [2:0]  in_srcs,
    input  logic [15:0] in_imm,
    output logic [15:0] alu_r,
    output logic [15:0] alu_s,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_y,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    output logic        done,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_e;
    localparam logic [3:0] OP_LOAD = 4'd13;

    state_e      state_q, state_d;
    logic        accept;
    logic [3:0]  op_q;
    logic [2:0]  dst_q, srcr_q, srcs_q;
    logic [15:0] imm_q, res_q;
    logic        tn_q, tz_q, tc_q;
    logic [15:0] rf_q [8];
    logic [15:0] alu_r_q, alu_s_q;
    logic [3:0]  alu_op_q;
    logic        done_q, fn_q, fz_q, fc_q;
    logic        is_alu;

    assign accept = in_valid & in_ready;
    assign is_alu = (op_q < OP_LOAD);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = (in_op < OP_LOAD) ? FETCH : WB;
            FETCH: state_d = EXEC;
            EXEC:  state_d = WB;
            WB:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            dst_q    <= '0;
            srcr_q   <= '0;
            srcs_q   <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            tn_q     <= 1'b0;
            tz_q     <= 1'b0;
            tc_q     <= 1'b0;
            alu_r_q  <= '0;
            alu_s_q  <= '0;
            alu_op_q <= '0;
            done_q   <= 1'b0;
            fn_q     <= 1'b0;
            fz_q     <= 1'b0;
            fc_q     <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            done_q <= (state_q == WB);
            if (accept) begin
                op_q   <= in_op;
                dst_q  <= in_dst;
                srcr_q <= in_srcr;
                srcs_q <= in_srcs;
                imm_q  <= in_imm;
            end
            if (state_q == FETCH) begin
                alu_r_q  <= rf_q[srcr_q];
                alu_s_q  <= rf_q[srcs_q];
                alu_op_q <= op_q;
            end
            if (state_q == EXEC) begin
                res_q <= alu_y;
                tn_q  <= alu_n;
                tz_q  <= alu_z;
                tc_q  <= alu_c;
            end
            // Sources were sampled at FETCH, so dst==src reads the pre-write value.
            if (state_q == WB) begin
                if (is_alu) begin
                    rf_q[dst_q] <= res_q;
                    fn_q <= tn_q;
                    fz_q <= tz_q;
                    fc_q <= tc_q;
                end else if (op_q == OP_LOAD) begin
                    rf_q[dst_q] <= imm_q;
                end
            end
        end
    end

    assign alu_r    = alu_r_q;
    assign alu_s    = alu_s_q;
    assign alu_op   = alu_op_q;
    assign done     = done_q;
    assign flag_n   = fn_q;
    assign flag_z   = fz_q;
    assign flag_c   = fc_q;
    assign dbg_data = rf_q[dbg_sel];
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus pushes expected write-back results, a monitor checks them on done.
module tb_alu_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_dst, in_srcr, in_srcs;
    logic [15:0] in_imm;
    logic [15:0] alu_r, alu_s, alu_y;
    logic [3:0]  alu_op;
    logic        alu_n, alu_z, alu_c;
    logic        done, flag_n, flag_z, flag_c;
    logic [2:0]  dbg_sel, stim_sel, mon_sel;
    logic        mon_own = 1'b0;
    logic [15:0] dbg_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [2:0]  dst;
        logic [15:0] val;
        logic        n, z, c;
        logic [3:0]  aop;
        int          done_cyc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dbg_sel = mon_own ? mon_sel : stim_sel;

    // Reference ALU for the opcodes exercised here: ADD=4, XOR=10, NEGATE=12.
    always_comb begin
        logic [16:0] sum;
        sum   = {1'b0, alu_r} + {1'b0, alu_s};
        alu_y = 16'h0000;
        alu_c = 1'b0;
        case (alu_op)
            4'd4:  begin alu_y = sum[15:0]; alu_c = sum[16]; end
            4'd10: begin alu_y = alu_r ^ alu_s; alu_c = 1'b0; end
            4'd12: begin alu_y = 16'h0000 - alu_s; alu_c = (alu_s != 16'h0000); end
            default: begin alu_y = 16'h0000; alu_c = 1'b0; end
        endcase
        alu_n = alu_y[15];
        alu_z = (alu_y == 16'h0000);
    end

    alu_seq_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dst(in_dst), .in_srcr(in_srcr), .in_srcs(in_srcs), .in_imm(in_imm),
        .alu_r(alu_r), .alu_s(alu_s), .alu_op(alu_op),
        .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
        .done(done), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input string nm, input logic [3:0] op, input logic [2:0] dst,
                        input logic [2:0] sr, input logic [2:0] ss, input logic [15:0] imm,
                        input logic [15:0] val, input logic n, input logic z, input logic c,
                        input logic [3:0] aop, input bit push, input bit hold, output int acc);
        int w;
        @(negedge clk);
        in_op = op; in_dst = dst; in_srcr = sr; in_srcs = ss; in_imm = imm; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) begin
            chk({nm, "_ready_timeout"}, 32'd1, 32'd0);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        if (push) q.push_back('{nm, dst, val, n, z, c, aop, cyc + ((op < 4'd13) ? 3 : 1)});
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 100) begin @(negedge clk); w++; end
        chk("drain_queue_empty", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_reset(input string nm);
        for (int i = 0; i < 8; i++) begin
            stim_sel = 3'(i); #1;
            chk($sformatf("%s_rf%0d", nm, i), dbg_data, 16'h0000);
        end
        chk({nm, "_flags"}, {flag_n, flag_z, flag_c}, 3'b000);
        chk({nm, "_alu_r"}, alu_r, 16'h0000);
        chk({nm, "_alu_s"}, alu_s, 16'h0000);
        chk({nm, "_alu_op"}, alu_op, 4'd0);
    endtask

    // Monitor: every done must match the oldest expectation, at the predicted cycle.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk("done_single_cycle", prev_done, 1'b0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    mon_sel = e.dst; mon_own = 1'b1; #1;
                    chk({e.name, "_rf"}, dbg_data, e.val);
                    chk({e.name, "_flags"}, {flag_n, flag_z, flag_c}, {e.n, e.z, e.c});
                    chk({e.name, "_alu_op"}, alu_op, e.aop);
                    chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
                    chk({e.name, "_ready_with_done"}, in_ready, 1'b1);
                    mon_own = 1'b0;
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    initial begin
        int a0, a1, w;
        stim_sel = 3'd0;
        reset = 1'b1; in_valid = 1'b1; in_op = 4'd13; in_dst = 3'd1;
        in_srcr = 3'd0; in_srcs = 3'd0; in_imm = 16'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_done", done, 1'b0);
        check_all_reset("reset");
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1'b1);
        stim_sel = 3'd1; #1;
        chk("post_reset_no_accept", dbg_data, 16'h0000);

        send("load_r1", 4'd13, 3'd1, 3'd0, 3'd0, 16'hBC45, 16'hBC45, 1'b0, 1'b0, 1'b0, 4'd0, 1, 0, a0);
        send("load_r2", 4'd13, 3'd2, 3'd0, 3'd0, 16'h86AB, 16'h86AB, 1'b0, 1'b0, 1'b0, 4'd0, 1, 0, a0);
        drain();

        // ADD with in_valid held through FETCH/EXEC/WB; a second accept would show as an extra done.
        send("add_r3", 4'd4, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h42F0, 1'b0, 1'b0, 1'b1, 4'd4, 1, 1, a0);
        @(posedge clk); #1;
        chk("add_alu_r", alu_r, 16'hBC45);
        chk("add_alu_s", alu_s, 16'h86AB);
        chk("add_alu_op", alu_op, 4'd4);
        w = 0;
        while (done !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("add_done_seen", (w < 20), 1'b1);
        in_valid = 1'b0;
        drain();

        send("xor_r3", 4'd10, 3'd3, 3'd3, 3'd3, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd10, 1, 0, a0);
        send("nop", 4'd14, 3'd3, 3'd1, 3'd2, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd10, 1, 0, a0);
        drain();

        send("load_r5", 4'd13, 3'd5, 3'd0, 3'd0, 16'hDF52, 16'hDF52, 1'b0, 1'b1, 1'b0, 4'd10, 1, 0, a0);
        send("neg_r6", 4'd12, 3'd6, 3'd0, 3'd5, 16'h0000, 16'h20AE, 1'b0, 1'b0, 1'b1, 4'd12, 1, 0, a1);
        chk("b2b_accept_gap", a1 - a0, 2);
        drain();

        // Abort an ADD in EXEC: nothing is expected on the scoreboard.
        send("abort_add", 4'd4, 3'd7, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd4, 0, 0, a0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1'b1);
        check_all_reset("abort");
        repeat (6) @(negedge clk);
        chk("abort_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that owns the 16-bit ALU (`alu16`) and an 8-entry × 16-bit register file. It accepts one instruction at a time over a valid/ready handshake and reads the two source registers. It then drives the ALU's R/S/Alu_Op inputs, captures Y and the N/Z/C flags, and writes the result back. It sits between the instruction source (test sequencer or future control unit) and the ALU datapath.

## Interface
Parameters:
- None. Data width is fixed at 16, the register file at 8 entries, and the op field at 4 bits.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  controller can accept an instruction; equals (state==IDLE) & ~reset.
- `in_op`  in  4  0–12 are ALU ops (Alu_Op encoding), 13 is LOAD, 14–15 are NOP.
- `in_dst`  in  3  destination register index.
- `in_srcr`  in  3  register index driven onto ALU R.
- `in_srcs`  in  3  register index driven onto ALU S.
- `in_imm`  in  16  immediate for LOAD.
- `alu_r`  out  16  registered ALU R operand.
- `alu_s`  out  16  registered ALU S operand.
- `alu_op`  out  4  registered ALU opcode.
- `alu_y`  in  16  ALU result.
- `alu_n`, `alu_z`, `alu_c`  in  1 each  ALU flags.
- `done`  out  1  one-cycle completion pulse.
- `flag_n`, `flag_z`, `flag_c`  out  1 each  latched flags of the last ALU instruction.
- `dbg_sel`  in  3  debug read index.
- `dbg_data`  out  16  combinational read of RF[dbg_sel].

## Operation
- Reset values: all 8 RF entries are 0. `alu_r`, `alu_s`, `alu_op`, `done` and the flags are 0. State is IDLE; `in_ready` is 0 while reset is high and 1 in the first cycle after.
- Handshake: an instruction is accepted on the edge where in_valid & in_ready. Op, dst, srcr, srcs and imm are captured into internal registers.
- While the state is not IDLE, `in_ready` is 0 and `in_valid` and the instruction fields are ignored.
- States are IDLE, FETCH, EXEC and WB. There is one transition per clock edge:
  - IDLE → FETCH on accept for op 0–12.
  - IDLE → WB on accept for op 13–15.
  - FETCH → EXEC. On this edge, `alu_r`←RF[srcr], `alu_s`←RF[srcs], `alu_op`←op.
  - EXEC → WB. On this edge, the result register ←`alu_y` and the flag temporaries ←`alu_n`/`alu_z`/`alu_c`.
  - WB → IDLE. On this edge, the write-back happens and `done`←1.
- Write-back:
  - ALU op: RF[dst]←result, and `flag_n`/`flag_z`/`flag_c`←captured flags.
  - LOAD: RF[dst]←imm; flags unchanged.
  - NOP: no RF write; flags unchanged.
- `alu_r`, `alu_s` and `alu_op` hold their values between instructions. LOAD and NOP never modify them.
- Source registers equal to dst (including srcr==srcs==dst) read pre-write values, because the read precedes the write by two edges.
- `done` is high for exactly one cycle, in the cycle after the WB→IDLE edge, then returns to 0.
- Reset mid-instruction: the instruction is aborted, with no write-back and no `done`. The RF and all outputs return to their reset values on that edge.

## Timing
- Accept edge E0.
- ALU op: operands valid at `alu_*` after E1; result captured at E2; RF and flags updated at E3. `done` is high in the cycle after E3, and `in_ready` is also 1 in that cycle. The next accept is possible at E4, giving a throughput of one ALU instruction per 4 cycles.
- LOAD/NOP: write (or nothing) at E1; `done` high in the cycle after E1. The next accept is at E2.
- The ALU is combinational and has one full cycle (EXEC) to settle.
- `dbg_data` reflects a write in the cycle immediately after the write edge.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid`=1. Required response:
  - every `dbg_sel` reads 0000;
  - flags, `done`, `alu_r`/`alu_s`/`alu_op` are 0;
  - `in_ready` is 0 during reset and 1 after;
  - no accept occurs during reset.
- LOAD R1=BC45, then LOAD R2=86AB. Required response:
  - each `done` pulses 1 cycle after E1;
  - `dbg` R1=BC45 and R2=86AB;
  - flags stay 0.
- ADD (op 4) dst=R3, srcr=R1, srcs=R2. Required response:
  - `alu_r`=BC45, `alu_s`=86AB, `alu_op`=4 after E1;
  - R3=42F0, N=0, Z=0, C=1 after E3;
  - `done` is high only in the cycle after E3;
  - `in_valid` held high during FETCH/EXEC/WB causes no second accept.
- XOR (op 10) dst=R3, srcr=R3, srcs=R3. Required response: R3=0000 and Z=1, N=0, C=0. Follow with NOP (op 14). Required response:
  - `done` after E1;
  - R3 and all flags unchanged;
  - `alu_op` still 10.
- Back-to-back: LOAD R5=DF52, then NEGATE (op 12) dst=R6, srcs=R5 accepted in the cycle `done` is high. Required response:
  - R6=20AE, C=1, N=0;
  - the second instruction is accepted exactly at E2 of the LOAD.
- Reset asserted for one cycle while in EXEC of ADD R7=R1+R2. Required response:
  - R7 and all RF entries are 0;
  - `done` never pulses;
  - the state is IDLE and `in_ready`=1 in the cycle after reset deasserts.
